accumulate_scan: RTL and testbench

Parametrised in-place scan engine over an internal single-port array. On a start strobe it walks indices `[init_i, init_end)`, adding each element to a running accumulator and optionally writing the running value back. It supports inclusive prefix sum, exclusive prefix sum and reduce-only modes. A host port can take over the array at any time to load inputs and read back results, which stalls the engine.

---
 rtl/accumulate_scan.sv | 161 ++++++++++++++++
 tb/tb_accumulate_scan.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulate_scan.sv
// accumulate_scan: in-place scan engine over an internal single-port array.
//
// A start strobe latches a range [init_i, init_end), a seed and a mode, then
// the FSM walks the range one element per four cycles (CHECK, READ, ADD,
// WRITE). Each element is added to a running accumulator. Depending on the
// mode, the running value is also written back to the array.
//   mode 0 = inclusive scan
//   mode 1 = exclusive scan
//   mode 2/3 = reduce-only
// The host can own the array port at any time; while it does, the engine
// freezes in place.
//
// Build option: define ACCUMULATE_SAT_EN to saturate the add instead of
// wrapping. In both builds, 'overflow' records a signed overflow sticky.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   r_enable             start strobe (also aborts a run in progress)
//   init_i/init_end      first / exclusive-last index (end clamped to DEPTH)
//   init_acc, mode       accumulator seed, scan mode
//   controlArr           host owns the array, engine stalls
//   controlArr*_a        host write enable / address / wdata / rdata
//   busy, w_enable       run in progress, done level (held until next start)
//   result, count        final accumulator, elements processed
//   overflow             sticky signed-overflow flag
module accumulate_scan #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_enable,
  input  logic [ADDR_W-1:0] init_i,
  input  logic [ADDR_W:0]   init_end,
  input  logic [DATA_W-1:0] init_acc,
  input  logic [1:0]        mode,
  input  logic              controlArr,
  input  logic              controlArrWEnable_a,
  input  logic [ADDR_W-1:0] controlArrAddr_a,
  input  logic [DATA_W-1:0] controlArrWData_a,
  output logic [DATA_W-1:0] controlArrRData_a,
  output logic              busy,
  output logic              w_enable,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]        state;
  // One bit wider than an address so the increment past DEPTH-1 cannot wrap.
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   end_q;
  logic [DATA_W-1:0] acc, prev, data_q;
  logic [1:0]        mode_q;

  logic              host_hit;
  logic              eng_wr;
  logic [DATA_W-1:0] sum, sat_val;
  logic              add_ovf;

  assign host_hit = controlArr && ({1'b0, controlArrAddr_a} < DEPTH_C);
  assign controlArrRData_a = host_hit ? mem[controlArrAddr_a] : 'x;

  // A start sampled on the WRITE edge aborts the run, so it also suppresses
  // that element's write-back.
  assign eng_wr = rst_n && !controlArr && !r_enable && (state == S_WRITE) &&
                  (mode_q != 2'd2);

  // Signed overflow: the operands share a sign and the sum does not.
  // On overflow, the saturated value follows the sign of the operands.
  assign sum     = acc + data_q;
  assign add_ovf = (acc[DATA_W-1] == data_q[DATA_W-1]) &&
                   (sum[DATA_W-1] != acc[DATA_W-1]);
  assign sat_val = {acc[DATA_W-1], {(DATA_W-1){~acc[DATA_W-1]}}};

  always_ff @(posedge clk) begin
    if (controlArr) begin
      if (controlArrWEnable_a && host_hit)
        mem[controlArrAddr_a] <= controlArrWData_a;
    end else if (eng_wr) begin
      mem[idx[ADDR_W-1:0]] <= (mode_q == 2'd0) ? acc : prev;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      end_q    <= '0;
      acc      <= '0;
      prev     <= '0;
      data_q   <= '0;
      mode_q   <= '0;
      busy     <= 1'b0;
      w_enable <= 1'b0;
      result   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (r_enable) begin
      idx      <= {1'b0, init_i};
      end_q    <= (init_end > DEPTH_C) ? DEPTH_C : init_end;
      acc      <= init_acc;
      mode_q   <= (mode == 2'd3) ? 2'd2 : mode;
      count    <= '0;
      w_enable <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b1;
      state    <= S_CHECK;
    end else if (!controlArr) begin
      case (state)
        S_IDLE: ;
        S_CHECK: state <= (idx >= end_q) ? S_DONE : S_READ;
        S_READ: begin
          data_q <= mem[idx[ADDR_W-1:0]];
          state  <= S_ADD;
        end
        S_ADD: begin
          prev <= acc;
`ifdef ACCUMULATE_SAT_EN
          acc  <= add_ovf ? sat_val : sum;
`else
          acc  <= sum;
`endif
          if (add_ovf) overflow <= 1'b1;
          state <= S_WRITE;
        end
        S_WRITE: begin
          idx   <= idx + 1'b1;
          count <= count + 1'b1;
          state <= S_CHECK;
        end
        S_DONE: begin
          result   <= acc;
          w_enable <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef ACCUMULATE_SAT_EN
  // In the wrapping build the saturated value is never selected.
  logic unused_sat;
  assign unused_sat = ^sat_val;
`endif

endmodule

// File: tb/tb_accumulate_scan.sv
// Scoreboard bench for accumulate_scan. Stimulus tasks push expected
// done/readback/status records into queues. Monitors at the falling edge
// pop and compare them when the DUT presents done or a host read/status
// sample is requested.
module tb_accumulate_scan;
  localparam int DW = 64;
  localparam int DEPTH = 1000;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0, r_enable = 1'b0;
  logic [AW-1:0] init_i = '0;
  logic [AW:0]   init_end = '0;
  logic [DW-1:0] init_acc = '0;
  logic [1:0]    mode = '0;
  logic          controlArr = 1'b0, cwe = 1'b0;
  logic [AW-1:0] caddr = '0;
  logic [DW-1:0] cwd = '0, crd;
  logic          busy, w_enable, overflow;
  logic [DW-1:0] result;
  logic [AW:0]   count;

  accumulate_scan #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_i(init_i),
    .init_end(init_end), .init_acc(init_acc), .mode(mode),
    .controlArr(controlArr), .controlArrWEnable_a(cwe),
    .controlArrAddr_a(caddr), .controlArrWData_a(cwd),
    .controlArrRData_a(crd), .busy(busy), .w_enable(w_enable),
    .result(result), .count(count), .overflow(overflow));

  typedef struct {
    logic [DW-1:0] res; int cnt; logic ovf; int lat; string nm;
  } done_t;
  typedef struct {
    logic b; logic we; logic [DW-1:0] res; int cnt; logic ovf; string nm;
  } stat_t;

  done_t         done_q[$];
  stat_t         stat_q[$];
  logic [DW-1:0] rd_q[$];
  string         rd_nm_q[$];

  int  n_chk = 0, n_fail = 0;
  int  since = 0;
  logic rd_strobe = 1'b0, stat_strobe = 1'b0, we_prev = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Cycles since the last sampled start edge (0 right after that edge).
  always @(posedge clk) since <= (rst_n && r_enable) ? 0 : since + 1;

  always @(negedge clk) begin
    if (rd_strobe) begin
      if (rd_q.size() == 0) fail_msg("read with no expectation");
      else chk(rd_nm_q.pop_front(), crd, rd_q.pop_front());
    end
    if (stat_strobe) begin
      if (stat_q.size() == 0) fail_msg("status with no expectation");
      else begin
        stat_t s;
        s = stat_q.pop_front();
        chk({s.nm, ".busy"}, 64'(busy), 64'(s.b));
        chk({s.nm, ".w_enable"}, 64'(w_enable), 64'(s.we));
        chk({s.nm, ".result"}, result, s.res);
        chk({s.nm, ".count"}, 64'(count), 64'(s.cnt));
        chk({s.nm, ".overflow"}, 64'(overflow), 64'(s.ovf));
      end
    end
    if (w_enable === 1'b1 && we_prev !== 1'b1) begin
      if (done_q.size() == 0) fail_msg("unexpected done");
      else begin
        done_t d;
        d = done_q.pop_front();
        chk({d.nm, ".result"}, result, d.res);
        chk({d.nm, ".count"}, 64'(count), 64'(d.cnt));
        chk({d.nm, ".overflow"}, 64'(overflow), 64'(d.ovf));
        chk({d.nm, ".latency"}, 64'(since), 64'(d.lat));
        chk({d.nm, ".busy"}, 64'(busy), 64'd0);
      end
    end
    we_prev <= w_enable;
  end

  task automatic tick;
    @(posedge clk); #1;
    rd_strobe = 1'b0;
    stat_strobe = 1'b0;
  endtask

  task automatic hw(input int a, input logic [DW-1:0] d);
    tick; controlArr = 1'b1; cwe = 1'b1; caddr = AW'(a); cwd = d;
  endtask

  task automatic hrd(input int a, input logic [DW-1:0] exp, input string nm);
    tick; controlArr = 1'b1; cwe = 1'b0; caddr = AW'(a);
    rd_q.push_back(exp); rd_nm_q.push_back(nm); rd_strobe = 1'b1;
  endtask

  task automatic load_seq;
    for (int k = 0; k < 10; k++) hw(k, DW'(k + 1));
  endtask

  task automatic start(input int i, input int e, input logic [DW-1:0] a,
                       input logic [1:0] m);
    tick; controlArr = 1'b0; cwe = 1'b0;
    r_enable = 1'b1; init_i = AW'(i); init_end = (AW+1)'(e);
    init_acc = a; mode = m;
    tick; r_enable = 1'b0;
  endtask

  task automatic exp_done(input logic [DW-1:0] r, input int c, input logic o,
                          input int lat, input string nm);
    done_t d;
    d.res = r; d.cnt = c; d.ovf = o; d.lat = lat; d.nm = nm;
    done_q.push_back(d);
  endtask

  task automatic stat(input logic b, input logic we, input logic [DW-1:0] r,
                      input int c, input logic o, input string nm);
    stat_t s;
    tick;
    s.b = b; s.we = we; s.res = r; s.cnt = c; s.ovf = o; s.nm = nm;
    stat_q.push_back(s); stat_strobe = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (w_enable !== 1'b1 && n < 200) begin tick; n++; end
    if (w_enable !== 1'b1) fail_msg({nm, " done timeout"});
  endtask

  initial begin
    repeat (3) tick;
    rst_n = 1'b1;
    stat(0, 0, 0, 0, 0, "reset");

    // Inclusive scan of 1..10.
    load_seq;
    start(0, 10, 0, 0);
    exp_done(55, 10, 0, 42, "incl");
    stat(1, 0, 0, 0, 0, "incl_busy");
    wait_done("incl");
    for (int k = 0; k < 10; k++)
      hrd(k, DW'((k + 1) * (k + 2) / 2), $sformatf("incl_mem%0d", k));

    // Exclusive scan seeded with 100.
    load_seq;
    start(0, 10, 100, 1);
    exp_done(155, 10, 0, 42, "excl");
    wait_done("excl");
    for (int k = 0; k < 10; k++)
      hrd(k, DW'(100 + k * (k + 1) / 2), $sformatf("excl_mem%0d", k));

    // Reduce-only over [3,6).
    load_seq;
    start(3, 6, 0, 2);
    exp_done(15, 3, 0, 14, "reduce");
    wait_done("reduce");
    for (int k = 3; k < 6; k++) hrd(k, DW'(k + 1), $sformatf("reduce_mem%0d", k));

    // Empty range keeps the seed.
    start(7, 7, -64'sd5, 0);
    exp_done(-64'sd5, 0, 0, 2, "empty");
    wait_done("empty");
    hrd(7, 8, "empty_mem7");

    // End clamped to DEPTH: last processed index is 999.
    for (int k = 0; k < 4; k++) hw(996 + k, DW'(k + 1));
    start(996, 1500, 0, 0);
    exp_done(10, 4, 0, 18, "clamp");
    wait_done("clamp");
    hrd(996, 1, "clamp_mem996");
    hrd(999, 10, "clamp_mem999");

    // Mode 3 behaves as reduce-only.
    hw(0, 10); hw(1, 20);
    start(0, 2, 0, 3);
    exp_done(30, 2, 0, 10, "mode3");
    wait_done("mode3");
    hrd(0, 10, "mode3_mem0");
    hrd(1, 20, "mode3_mem1");

    // Host holds the array for 5 edges mid-run: done 5 cycles late.
    load_seq;
    start(0, 4, 0, 0);
    exp_done(10, 4, 0, 23, "stall");
    repeat (3) tick;
    controlArr = 1'b1; caddr = '0;
    repeat (5) tick;
    controlArr = 1'b0;
    wait_done("stall");
    for (int k = 0; k < 4; k++)
      hrd(k, DW'((k + 1) * (k + 2) / 2), $sformatf("stall_mem%0d", k));

    // Restart on the WRITE edge of element 1: that write must be dropped.
    load_seq;
    start(0, 10, 0, 0);
    repeat (6) tick;
    start(0, 3, 1, 2);
    exp_done(7, 3, 0, 14, "restart");
    wait_done("restart");
    hrd(0, 1, "restart_mem0");
    hrd(1, 2, "restart_mem1");

    // Reset mid-run clears every status output.
    start(0, 10, 0, 0);
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    stat(0, 0, 0, 0, 0, "midreset");

    // Signed overflow on max + 1.
    hw(0, 64'h7fff_ffff_ffff_ffff); hw(1, 1);
    start(0, 2, 0, 2);
`ifdef ACCUMULATE_SAT_EN
    exp_done(64'h7fff_ffff_ffff_ffff, 2, 1, 10, "ovf");
`else
    exp_done(64'h8000_0000_0000_0000, 2, 1, 10, "ovf");
`endif
    wait_done("ovf");

    repeat (3) tick;
    controlArr = 1'b0;
    if (done_q.size() != 0) fail_msg("done expectations left unmatched");
    if (rd_q.size() != 0) fail_msg("read expectations left unmatched");
    if (stat_q.size() != 0) fail_msg("status expectations left unmatched");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
